dcache: RTL

DCACHE -- requirements
Module: dcache

---
 rtl/dcache_if.sv | 32 +++
 rtl/dcache.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dcache_if.sv
// CPU and backing-memory signal bundle for the direct-mapped data cache.
// The master side is the CPU plus memory agent; the slave side is the cache.
interface dcache_if #(
  parameter int unsigned WD_SIZE    = 32,
  parameter int unsigned LINE_WORDS = 4
);
  logic                          req_en_i;
  logic                          req_rd_wr_i;
  logic [WD_SIZE-1:0]            req_addr_i;
  logic [WD_SIZE-1:0]            req_wr_data_i;
  logic [WD_SIZE-1:0]            req_wr_keep_i;
  logic [WD_SIZE-1:0]            rd_data_o;
  logic                          stall_o;
  logic                          mem_req_o;
  logic                          mem_we_o;
  logic [WD_SIZE-1:0]            mem_addr_o;
  logic [WD_SIZE*LINE_WORDS-1:0] mem_wr_data_o;
  logic [WD_SIZE*LINE_WORDS-1:0] mem_rd_data_i;
  logic                          mem_ack_i;

  modport master (
    output req_en_i, req_rd_wr_i, req_addr_i, req_wr_data_i, req_wr_keep_i,
    output mem_rd_data_i, mem_ack_i,
    input  rd_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o
  );

  modport slave (
    input  req_en_i, req_rd_wr_i, req_addr_i, req_wr_data_i, req_wr_keep_i,
    input  mem_rd_data_i, mem_ack_i,
    output rd_data_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with zero-latency hits.
// Misses stall the CPU while the victim is written back and the line refilled.
module dcache #(
  parameter int unsigned WD_SIZE    = 32,
  parameter int unsigned LINES      = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic     clk,
  input  logic     reset,
  dcache_if.slave  bus
);
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WSEL_W + 2;
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = WD_SIZE - OFF_W - IDX_W;
  localparam int unsigned LINE_W = WD_SIZE * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Miss index/tag are latched so the transfer survives req_en_i dropping.
  logic [IDX_W-1:0]  miss_idx_q;
  logic [TAG_W-1:0]  miss_tag_q;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [WSEL_W-1:0]  req_wsel;
  logic               unused_addr_bits;
  logic               hit_c;
  logic               store_hit_c;
  logic               refill_done_c;
  logic               miss_capture_c;
  logic               stall_c;
  logic               mem_req_c;
  logic               mem_we_c;
  logic [WD_SIZE-1:0] mem_addr_c;
  logic [WD_SIZE-1:0] cur_word_c;
  logic [LINE_W-1:0]  merged_line_c;

  assign req_idx          = bus.req_addr_i[OFF_W +: IDX_W];
  assign req_tag          = bus.req_addr_i[WD_SIZE-1 -: TAG_W];
  assign req_wsel         = bus.req_addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^bus.req_addr_i[1:0];

  assign hit_c         = bus.req_en_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign store_hit_c   = (state_q == IDLE) & hit_c & bus.req_rd_wr_i & ~reset;
  assign refill_done_c = (state_q == REFILL) & bus.mem_ack_i & ~reset;

  // Word select for loads and bit-masked merge for stores.
  always_comb begin
    cur_word_c    = '0;
    merged_line_c = data_q[req_idx];
    for (int unsigned w = 0; w < LINE_WORDS; w++) begin
      if (req_wsel == WSEL_W'(w)) begin
        cur_word_c = data_q[req_idx][w*WD_SIZE +: WD_SIZE];
        merged_line_c[w*WD_SIZE +: WD_SIZE] =
          (data_q[req_idx][w*WD_SIZE +: WD_SIZE] & ~bus.req_wr_keep_i) |
          (bus.req_wr_data_i & bus.req_wr_keep_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    stall_c        = 1'b0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_c     = '0;
    miss_capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_en_i && !hit_c) begin
          stall_c        = 1'b1;
          miss_capture_c = 1'b1;
          state_d        = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        mem_addr_c = {tag_q[miss_idx_q], miss_idx_q, OFF_W'(0)};
        if (bus.mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {miss_tag_q, miss_idx_q, OFF_W'(0)};
        if (bus.mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d        = IDLE;
      stall_c        = 1'b0;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      miss_capture_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (refill_done_c) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (store_hit_c) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Data, tag and miss registers carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (refill_done_c) begin
        data_q[miss_idx_q] <= bus.mem_rd_data_i;
        tag_q[miss_idx_q]  <= miss_tag_q;
      end
      if (store_hit_c) data_q[req_idx] <= merged_line_c;
      if (miss_capture_c) begin
        miss_idx_q <= req_idx;
        miss_tag_q <= req_tag;
      end
    end
  end

  assign bus.rd_data_o     = cur_word_c;
  assign bus.stall_o       = stall_c;
  assign bus.mem_req_o     = mem_req_c;
  assign bus.mem_we_o      = mem_we_c;
  assign bus.mem_addr_o    = mem_addr_c;
  assign bus.mem_wr_data_o = data_q[miss_idx_q];
endmodule
